// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: reset PC default, the NOP word used to fill
// an empty IF/ID register, the fetch FSM encoding and the skid entry layout.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    localparam logic [1:0] FS_IDLE  = 2'd0;
    localparam logic [1:0] FS_FETCH = 2'd1;
    localparam logic [1:0] FS_WAIT  = 2'd2;
    localparam logic [1:0] FS_HOLD  = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory request/response bus.
//   imem_req_valid / imem_req_ready / imem_addr : request handshake
//   imem_rsp_valid / imem_rsp_data               : response, one per accepted request
// master = fetch unit, slave = instruction memory.
interface instruction_fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/if_skid_buffer.sv
// One-entry skid buffer holding a fetched (pc, instruction) pair while the
// IF/ID register is blocked by decode.
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : capture load_entry
//   unload      : entry consumed by the IF/ID register
//   flush       : discard entry (redirect); wins over load
//   valid/entry : current contents
module if_skid_buffer
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         unload,
    input  logic         flush,
    input  fetch_entry_t load_entry,
    output logic         valid,
    output fetch_entry_t entry
);

    logic         valid_q, valid_d;
    fetch_entry_t entry_q, entry_d;

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            entry_d = load_entry;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid = valid_q;
    assign entry = entry_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch stage feeding the IF/ID register.
//   clk, rst_n           : clock, synchronous active-low reset
//   imem (master)        : instruction memory request/response bus
//   redirect_valid/_pc   : branch/jump redirect from execute (overrides all)
//   stall                : decode cannot accept a new instruction
//   id_valid/_pc/_instruction : IF/ID register
//   misaligned_redirect  : one-cycle pulse after a redirect with pc[1:0] != 0
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    instruction_fetch_unit_if.master        imem,
    input  logic                            redirect_valid,
    input  logic [31:0]                     redirect_pc,
    input  logic                            stall,
    output logic                            id_valid,
    output logic [31:0]                     id_pc,
    output logic [31:0]                     id_instruction,
    output logic                            misaligned_redirect
);

    logic [1:0]   state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         drop_q, drop_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic         misaligned_q, misaligned_d;

    logic         out_free;
    logic         skid_load, skid_unload, skid_flush, skid_valid;
    fetch_entry_t skid_entry, rsp_entry;

    assign out_free  = !id_valid_q || !stall;
    assign rsp_entry = '{pc: fetch_pc_q, instr: imem.imem_rsp_data};

    if_skid_buffer u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .unload     (skid_unload),
        .flush      (skid_flush),
        .load_entry (rsp_entry),
        .valid      (skid_valid),
        .entry      (skid_entry)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        drop_d       = drop_q;
        id_valid_d   = id_valid_q && stall;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_flush   = 1'b0;
        misaligned_d = redirect_valid && (redirect_pc[1:0] != 2'b00);

        if (redirect_valid) begin
            pc_d       = align_word(redirect_pc);
            id_valid_d = 1'b0;
            skid_flush = 1'b1;
            state_d    = FS_FETCH;
            drop_d     = drop_q && !imem.imem_rsp_valid;
            // A request that is (or becomes) outstanding belongs to the old
            // path: wait for its response and throw it away.
            if ((state_q == FS_FETCH && imem.imem_req_ready) ||
                (state_q == FS_WAIT && !imem.imem_rsp_valid)) begin
                state_d = FS_WAIT;
                drop_d  = 1'b1;
            end
        end else begin
            // A late response left over from a reset can arrive in any state.
            if (imem.imem_rsp_valid && drop_q) begin
                drop_d = 1'b0;
            end
            case (state_q)
                FS_IDLE: state_d = FS_FETCH;
                FS_FETCH: begin
                    if (imem.imem_req_ready) begin
                        state_d    = FS_WAIT;
                        fetch_pc_d = pc_q;
                    end
                end
                FS_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        if (drop_q) begin
                            state_d = FS_FETCH;
                        end else begin
                            pc_d = fetch_pc_q + 32'd4;
                            if (out_free) begin
                                id_valid_d = 1'b1;
                                id_pc_d    = fetch_pc_q;
                                id_instr_d = imem.imem_rsp_data;
                                state_d    = FS_FETCH;
                            end else begin
                                skid_load = 1'b1;
                                state_d   = FS_HOLD;
                            end
                        end
                    end
                end
                FS_HOLD: begin
                    if (out_free && skid_valid) begin
                        id_valid_d  = 1'b1;
                        id_pc_d     = skid_entry.pc;
                        id_instr_d  = skid_entry.instr;
                        skid_unload = 1'b1;
                        state_d     = FS_FETCH;
                    end
                end
                default: state_d = FS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FS_IDLE;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= RESET_PC;
            // Remember a request left in flight so its response is ignored later.
            drop_q       <= (state_q == FS_WAIT || drop_q) && !imem.imem_rsp_valid;
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_instr_q   <= NOP_INSTR;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            drop_q       <= drop_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign imem.imem_req_valid = rst_n && (state_q == FS_FETCH);
    assign imem.imem_addr      = pc_q;
    assign id_valid            = id_valid_q;
    assign id_pc               = id_pc_q;
    assign id_instruction      = id_instr_q;
    assign misaligned_redirect = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic        misaligned_redirect;

    int n_total = 0;
    int n_bad   = 0;

    instruction_fetch_unit_if imem ();

    instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .imem                (imem),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .stall               (stall),
        .id_valid            (id_valid),
        .id_pc               (id_pc),
        .id_instruction      (id_instruction),
        .misaligned_redirect (misaligned_redirect)
    );

    always #5 clk = ~clk;

    // Memory model: one request at a time, latency chosen at acceptance,
    // data tagged with the epoch current at acceptance.
    int unsigned ready_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    logic [31:0] mem_epoch = '0;
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_epoch_q;
    int unsigned mem_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] ep);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678 ^ ep;
    endfunction

    initial begin
        bit          hs, fire;
        logic [31:0] a;
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            hs   = imem.imem_req_valid && imem.imem_req_ready;
            a    = imem.imem_addr;
            fire = imem.imem_rsp_valid;
            @(posedge clk);
            #1;
            if (fire) begin
                imem.imem_rsp_valid = 1'b0;
                imem.imem_rsp_data  = $urandom;
                mem_busy = 1'b0;
            end
            if (hs) begin
                mem_busy    = 1'b1;
                mem_addr_q  = a;
                mem_epoch_q = mem_epoch;
                mem_cnt     = $urandom_range(lat_max, lat_min);
            end
            if (mem_busy && !imem.imem_rsp_valid) begin
                if (mem_cnt <= 1) begin
                    imem.imem_rsp_valid = 1'b1;
                    imem.imem_rsp_data  = mem_word(mem_addr_q, mem_epoch_q);
                end else begin
                    mem_cnt--;
                end
            end
            imem.imem_req_ready = !mem_busy && ($urandom_range(99, 0) < ready_pct);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        stall = 1'b0;
        tick();
        for (int k = 0; k < 100 && mem_busy; k++) tick();
        repeat (3) tick();
        mem_epoch = $urandom;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ready_pct = 100; lat_min = 1; lat_max = 1;
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_total++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rst_id_valid got=%0b exp=0", id_valid); end
        n_total++; if (id_pc !== 32'h0) begin n_bad++; $display("FAIL rst_id_pc got=%h exp=0", id_pc); end
        n_total++; if (id_instruction !== 32'h0000_0013) begin n_bad++; $display("FAIL rst_id_instr got=%h exp=00000013", id_instruction); end
        n_total++; if (misaligned_redirect !== 1'b0) begin n_bad++; $display("FAIL rst_misaligned got=%0b exp=0", misaligned_redirect); end
        n_total++; if (imem.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid got=%0b exp=0", imem.imem_req_valid); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (imem.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rel_cycle1_req got=%0b exp=0", imem.imem_req_valid); end
        @(negedge clk);
        n_total++; if (imem.imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rel_cycle2_req got=%0b exp=1", imem.imem_req_valid); end
        n_total++; if (imem.imem_addr !== RST_PC) begin n_bad++; $display("FAIL rel_first_addr got=%h exp=%h", imem.imem_addr, RST_PC); end
    endtask

    task automatic test_sequential();
        int got;
        int last;
        logic [31:0] e;
        ready_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        got = 0; last = 0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            @(negedge clk);
            if (id_valid) begin
                e = RST_PC + 32'(4 * got);
                n_total++; if (id_pc !== e) begin n_bad++; $display("FAIL seq_pc got=%h exp=%h", id_pc, e); end
                n_total++; if (id_instruction !== mem_word(e, mem_epoch)) begin n_bad++; $display("FAIL seq_instr got=%h exp=%h", id_instruction, mem_word(e, mem_epoch)); end
                if (got > 0) begin
                    n_total++; if (c - last != 2) begin n_bad++; $display("FAIL seq_gap got=%0d exp=2", c - last); end
                end
                last = c;
                got++;
            end
        end
        n_total++; if (got != 3) begin n_bad++; $display("FAIL seq_count got=%0d exp=3", got); end
    endtask

    task automatic test_stall();
        int c;
        ready_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        stall = 1'b1;
        c = 0;
        do begin @(negedge clk); c++; end while (!id_valid && c < 30);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_total++; if ({id_valid, id_pc, id_instruction} !== {1'b1, RST_PC, mem_word(RST_PC, mem_epoch)}) begin
                n_bad++; $display("FAIL stall_hold got=%0b/%h/%h exp=1/%h/%h", id_valid, id_pc, id_instruction, RST_PC, mem_word(RST_PC, mem_epoch));
            end
        end
        tick();
        stall = 1'b0;
        @(negedge clk);
        n_total++; if ({id_valid, id_pc} !== {1'b1, RST_PC}) begin n_bad++; $display("FAIL stall_drop_cycle got=%0b/%h exp=1/%h", id_valid, id_pc, RST_PC); end
        @(negedge clk);
        n_total++; if ({id_valid, id_pc, id_instruction} !== {1'b1, RST_PC + 32'd4, mem_word(RST_PC + 32'd4, mem_epoch)}) begin
            n_bad++; $display("FAIL stall_buffered got=%0b/%h/%h exp=1/%h", id_valid, id_pc, id_instruction, RST_PC + 32'd4);
        end
        @(negedge clk);
        n_total++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL stall_no_dup got=%0b/%h exp=0", id_valid, id_pc); end
        c = 0;
        do begin @(negedge clk); c++; end while (!id_valid && c < 30);
        n_total++; if ({id_valid, id_pc} !== {1'b1, RST_PC + 32'd8}) begin n_bad++; $display("FAIL stall_next got=%0b/%h exp=1/%h", id_valid, id_pc, RST_PC + 32'd8); end
    endtask

    task automatic test_redirect_wait();
        int c;
        bit seen_req, seen_id;
        ready_pct = 100; lat_min = 4; lat_max = 4;
        do_reset();
        c = 0;
        do begin @(negedge clk); c++; end while (!(imem.imem_req_valid && imem.imem_req_ready) && c < 30);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        seen_req = 0; seen_id = 0;
        for (int k = 0; k < 40 && !seen_id; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_total++; if ({id_valid, misaligned_redirect} !== 2'b00) begin n_bad++; $display("FAIL rw_after got=%0b/%0b exp=0/0", id_valid, misaligned_redirect); end
            end
            if (imem.imem_req_valid && !seen_req) begin
                seen_req = 1;
                n_total++; if (imem.imem_addr !== 32'h100) begin n_bad++; $display("FAIL rw_addr got=%h exp=00000100", imem.imem_addr); end
            end
            if (id_valid) begin
                seen_id = 1;
                n_total++; if ({id_pc, id_instruction} !== {32'h100, mem_word(32'h100, mem_epoch)}) begin
                    n_bad++; $display("FAIL rw_id got=%h/%h exp=00000100/%h", id_pc, id_instruction, mem_word(32'h100, mem_epoch));
                end
            end
        end
        n_total++; if (!seen_id) begin n_bad++; $display("FAIL rw_timeout got=0 exp=1"); end
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_redirect_hold();
        int c;
        ready_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        stall = 1'b1;
        c = 0;
        do begin @(negedge clk); c++; end while (!id_valid && c < 30);
        repeat (3) @(negedge clk);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_total++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rh_id_valid got=%0b exp=0", id_valid); end
        n_total++; if ({imem.imem_req_valid, imem.imem_addr} !== {1'b1, 32'h200}) begin
            n_bad++; $display("FAIL rh_req got=%0b/%h exp=1/00000200", imem.imem_req_valid, imem.imem_addr);
        end
        stall = 1'b0;
        c = 0;
        do begin @(negedge clk); c++; end while (!id_valid && c < 30);
        n_total++; if ({id_valid, id_pc, id_instruction} !== {1'b1, 32'h200, mem_word(32'h200, mem_epoch)}) begin
            n_bad++; $display("FAIL rh_next got=%0b/%h/%h exp=1/00000200", id_valid, id_pc, id_instruction);
        end
    endtask

    task automatic test_misaligned();
        int c;
        bit seen_req, seen_id;
        ready_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        c = 0;
        do begin @(negedge clk); c++; end while (!id_valid && c < 30);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        @(negedge clk);
        n_total++; if (misaligned_redirect !== 1'b0) begin n_bad++; $display("FAIL mis_early got=%0b exp=0", misaligned_redirect); end
        tick();
        redirect_valid = 1'b0;
        seen_req = 0; seen_id = 0;
        for (int k = 0; k < 40 && !seen_id; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_total++; if (misaligned_redirect !== 1'b1) begin n_bad++; $display("FAIL mis_pulse got=%0b exp=1", misaligned_redirect); end
            end
            if (k == 1) begin
                n_total++; if (misaligned_redirect !== 1'b0) begin n_bad++; $display("FAIL mis_end got=%0b exp=0", misaligned_redirect); end
            end
            if (imem.imem_req_valid && !seen_req) begin
                seen_req = 1;
                n_total++; if (imem.imem_addr !== 32'h100) begin n_bad++; $display("FAIL mis_addr got=%h exp=00000100", imem.imem_addr); end
            end
            if (id_valid) begin
                seen_id = 1;
                n_total++; if (id_pc !== 32'h100) begin n_bad++; $display("FAIL mis_id_pc got=%h exp=00000100", id_pc); end
            end
        end
        n_total++; if (!seen_id) begin n_bad++; $display("FAIL mis_timeout got=0 exp=1"); end
    endtask

    task automatic test_reset_mid_wait();
        int c;
        bit seen_id;
        ready_pct = 100; lat_min = 6; lat_max = 6;
        do_reset();
        c = 0;
        do begin @(negedge clk); c++; end while (!(imem.imem_req_valid && imem.imem_req_ready) && c < 30);
        tick();
        rst_n = 1'b0;
        mem_epoch = mem_epoch ^ 32'h5A5A_1111;
        @(negedge clk);
        n_total++; if ({id_valid, imem.imem_req_valid, id_instruction} !== {2'b00, 32'h0000_0013}) begin
            n_bad++; $display("FAIL rmw_in_reset got=%0b/%0b/%h exp=0/0/00000013", id_valid, imem.imem_req_valid, id_instruction);
        end
        tick();
        rst_n = 1'b1;
        seen_id = 0;
        for (int k = 0; k < 60 && !seen_id; k++) begin
            @(negedge clk);
            if (id_valid) begin
                seen_id = 1;
                n_total++; if ({id_pc, id_instruction} !== {RST_PC, mem_word(RST_PC, mem_epoch)}) begin
                    n_bad++; $display("FAIL rmw_first got=%h/%h exp=%h/%h", id_pc, id_instruction, RST_PC, mem_word(RST_PC, mem_epoch));
                end
            end
        end
        n_total++; if (!seen_id) begin n_bad++; $display("FAIL rmw_timeout got=0 exp=1"); end
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, prev_pc, prev_instr, prev_red_pc, tmp;
        bit prev_valid, prev_stall, prev_red, exp_mis;
        int delivered;
        ready_pct = 60; lat_min = 1; lat_max = 3;
        do_reset();
        exp_pc = RST_PC;
        prev_valid = 0; prev_stall = 0; prev_red = 0;
        prev_pc = '0; prev_instr = '0; prev_red_pc = '0;
        delivered = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc > 0) tick();
            stall = ($urandom_range(99, 0) < 30);
            redirect_valid = ($urandom_range(99, 0) < 4);
            tmp = $urandom;
            redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | (tmp & 32'hF)) : (tmp & 32'h0000_3FFF);
            @(negedge clk);
            exp_mis = prev_red && (prev_red_pc[1:0] != 2'b00);
            n_total++; if (misaligned_redirect !== exp_mis) begin n_bad++; $display("FAIL rnd_mis cyc=%0d got=%0b exp=%0b", cyc, misaligned_redirect, exp_mis); end
            if (prev_red) begin
                n_total++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_redirect_kill cyc=%0d got=%0b exp=0", cyc, id_valid); end
            end else if (prev_valid && prev_stall) begin
                n_total++; if ({id_valid, id_pc, id_instruction} !== {1'b1, prev_pc, prev_instr}) begin
                    n_bad++; $display("FAIL rnd_hold cyc=%0d got=%0b/%h/%h exp=1/%h/%h", cyc, id_valid, id_pc, id_instruction, prev_pc, prev_instr);
                end
            end
            if (!redirect_valid && id_valid && !stall) begin
                n_total++; if ({id_pc, id_instruction} !== {exp_pc, mem_word(exp_pc, mem_epoch)}) begin
                    n_bad++; $display("FAIL rnd_stream cyc=%0d got=%h/%h exp=%h/%h", cyc, id_pc, id_instruction, exp_pc, mem_word(exp_pc, mem_epoch));
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
            prev_valid = id_valid; prev_stall = stall; prev_red = redirect_valid;
            prev_pc = id_pc; prev_instr = id_instruction; prev_red_pc = redirect_pc;
        end
        tick();
        redirect_valid = 1'b0;
        stall = 1'b0;
        n_total++; if (delivered < 50) begin n_bad++; $display("FAIL rnd_progress got=%0d exp>=50", delivered); end
    endtask

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_misaligned();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
